// File: rtl/cut_cmd_tx.sv
// Command transmitter for the cutting controller: holds each command code on Dout, then idles between commands.
// Define CUT_CMD_TX_FIFO_EN to put a 4-entry command FIFO between the handshake and the FSM.
module cut_cmd_tx #(
    parameter int HOLD_CYCLES = 40,
    parameter int GAP_CYCLES  = 40
) (
    input  logic       clk40MHz,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [4:0] cmd_code,
    output logic       cmd_ready,
    input  logic       estop,
    output logic [4:0] Dout,
    output logic       busy,
    output logic       cmd_err,
    output logic [7:0] sent_cnt
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [4:0]    IDLE_CODE  = 5'd31;
    localparam logic [4:0]    STOP_CODE  = 5'd22;
    localparam logic [4:0]    LAST_VALID = 5'd25;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    dout_nxt;
    logic          enter_hold;
    logic          estop_q;
    logic          estop_first;
    logic          xfer;
    logic          code_ok;
    logic          cmd_avail;
    logic [4:0]    cmd_head;

    assign xfer        = cmd_valid && cmd_ready;
    assign code_ok     = cmd_code <= LAST_VALID;
    assign estop_first = estop && !estop_q;

`ifdef CUT_CMD_TX_FIFO_EN
    logic [4:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_count;
    logic       push;
    logic       pop;

    assign cmd_ready = (fifo_count != 3'd4) && !estop && !rst;
    assign push      = xfer && code_ok;
    assign cmd_avail = fifo_count != 3'd0;
    assign cmd_head  = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE) || (fifo_count != 3'd0);

    // Emergency stop flushes everything still queued.
    always_ff @(posedge clk40MHz) begin
        if (rst || estop) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= cmd_code;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
`else
    assign cmd_ready = (state == IDLE) && !estop && !rst;
    assign cmd_avail = xfer && code_ok;
    assign cmd_head  = cmd_code;
    assign busy      = state != IDLE;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dout_nxt   = Dout;
        enter_hold = 1'b0;
`ifdef CUT_CMD_TX_FIFO_EN
        pop        = 1'b0;
`endif
        if (estop_first || (estop && state == IDLE)) begin
            state_nxt  = HOLD;
            cnt_nxt    = HOLD_LOAD;
            dout_nxt   = STOP_CODE;
            enter_hold = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_avail) begin
                        state_nxt  = HOLD;
                        cnt_nxt    = HOLD_LOAD;
                        dout_nxt   = cmd_head;
                        enter_hold = 1'b1;
`ifdef CUT_CMD_TX_FIFO_EN
                        pop        = 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                        dout_nxt  = IDLE_CODE;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                GAP: begin
                    // A pending command starts straight from the last gap cycle so the gap stays exact.
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CW'(1);
                    end else if (estop) begin
                        state_nxt  = HOLD;
                        cnt_nxt    = HOLD_LOAD;
                        dout_nxt   = STOP_CODE;
                        enter_hold = 1'b1;
                    end else if (cmd_avail) begin
                        state_nxt  = HOLD;
                        cnt_nxt    = HOLD_LOAD;
                        dout_nxt   = cmd_head;
                        enter_hold = 1'b1;
`ifdef CUT_CMD_TX_FIFO_EN
                        pop        = 1'b1;
`endif
                    end else begin
                        state_nxt = IDLE;
                        dout_nxt  = IDLE_CODE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    dout_nxt  = IDLE_CODE;
                end
            endcase
        end
    end

    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            Dout     <= IDLE_CODE;
            sent_cnt <= 8'd0;
            cmd_err  <= 1'b0;
            estop_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            Dout     <= dout_nxt;
            estop_q  <= estop;
            cmd_err  <= xfer && !code_ok;
            if (enter_hold) begin
                sent_cnt <= sent_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cut_cmd_tx.sv
// Directed self-checking bench for cut_cmd_tx; follows CUT_CMD_TX_FIFO_EN for the FIFO-dependent expectations.
module tb_cut_cmd_tx;

    logic       clk40MHz;
    logic       rst;
    logic       cmd_valid;
    logic [4:0] cmd_code;
    logic       cmd_ready;
    logic       estop;
    logic [4:0] Dout;
    logic       busy;
    logic       cmd_err;
    logic [7:0] sent_cnt;

    int checks = 0;
    int errors = 0;

`ifdef CUT_CMD_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    cut_cmd_tx dut (
        .clk40MHz (clk40MHz),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_ready(cmd_ready),
        .estop    (estop),
        .Dout     (Dout),
        .busy     (busy),
        .cmd_err  (cmd_err),
        .sent_cnt (sent_cnt)
    );

    initial clk40MHz = 1'b0;
    always #12 clk40MHz = ~clk40MHz;

    task automatic tick();
        @(posedge clk40MHz);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Waits for the block to accept, then presents one code for exactly one transfer edge.
    task automatic applyStimulus(input logic [4:0] code);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            tick();
            n++;
        end
        if (!cmd_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_code  = code;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_code  = 5'd0;
        estop     = 1'b0;
        tick();
        tick();
        checkOutput("rst_dout", Dout, 31);
        checkOutput("rst_ready", cmd_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", cmd_err, 0);
        checkOutput("rst_sent", sent_cnt, 0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", cmd_ready, 1);

        // Single command: 40 cycles of the code followed by 40 cycles of idle.
        applyStimulus(5'd5);
        for (int k = 1; k <= 80 + LAT; k++) begin
            checkOutput("t1_dout", Dout, (k >= LAT && k < LAT + 40) ? 32'd5 : 32'd31);
`ifndef CUT_CMD_TX_FIFO_EN
            checkOutput("t1_ready", cmd_ready, (k == 81) ? 32'd1 : 32'd0);
`endif
            if (k < 80 + LAT) tick();
        end
        checkOutput("t1_sent", sent_cnt, 1);
        checkOutput("t1_busy", busy, 0);

        // Invalid codes at and beyond the boundary are rejected with an error pulse.
        cmd_valid = 1'b1;
        cmd_code  = 5'd27;
        #1;
        checkOutput("t2_ready", cmd_ready, 1);
        tick();
        cmd_code = 5'd26;
        checkOutput("t2_err27", cmd_err, 1);
        checkOutput("t2_dout27", Dout, 31);
        tick();
        cmd_valid = 1'b0;
        checkOutput("t2_err26", cmd_err, 1);
        tick();
        checkOutput("t2_err_clear", cmd_err, 0);
        checkOutput("t2_busy", busy, 0);
        checkOutput("t2_dout", Dout, 31);
        checkOutput("t2_sent", sent_cnt, 1);

        // Highest valid code, then reset in HOLD cycle 17.
        applyStimulus(5'd25);
        for (int k = 1; k < LAT; k++) tick();
        checkOutput("t3_dout", Dout, 25);
        checkOutput("t3_sent", sent_cnt, 2);
        for (int k = 0; k < 16; k++) tick();
        checkOutput("t3_dout17", Dout, 25);
        rst = 1'b1;
        tick();
        checkOutput("t3_rst_dout", Dout, 31);
        checkOutput("t3_rst_busy", busy, 0);
        checkOutput("t3_rst_sent", sent_cnt, 0);
        checkOutput("t3_rst_ready", cmd_ready, 0);
        rst = 1'b0;
        tick();

        // Lowest code and latency.
        applyStimulus(5'd0);
`ifdef CUT_CMD_TX_FIFO_EN
        checkOutput("t4_dout_early", Dout, 31);
        tick();
`endif
        checkOutput("t4_dout", Dout, 0);
        checkOutput("t4_sent", sent_cnt, 1);
        waitIdle(200);

        // Estop in the same cycle as an offered command: estop wins, no error.
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_code  = 5'd7;
        #1;
        checkOutput("t5_ready", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        estop     = 1'b0;
        checkOutput("t5_dout", Dout, 22);
        checkOutput("t5_err", cmd_err, 0);
        checkOutput("t5_sent", sent_cnt, 2);
        waitIdle(200);
        checkOutput("t5_sent_end", sent_cnt, 2);
        checkOutput("t5_dout_end", Dout, 31);

        // Estop mid-HOLD (with queued commands when the FIFO is present), held through one repeat.
        applyStimulus(5'd10);
`ifdef CUT_CMD_TX_FIFO_EN
        applyStimulus(5'd11);
        applyStimulus(5'd12);
`endif
        for (int k = 0; k < 4; k++) tick();
        checkOutput("t6_dout10", Dout, 10);
        estop = 1'b1;
        tick();
        checkOutput("t6_ready", cmd_ready, 0);
        checkOutput("t6_sent", sent_cnt, 4);
        for (int k = 1; k <= 81; k++) begin
            checkOutput("t6_dout", Dout, (k <= 40 || k == 81) ? 32'd22 : 32'd31);
            if (k < 81) tick();
        end
        checkOutput("t6_sent_rep", sent_cnt, 5);
        estop = 1'b0;
        for (int k = 82; k <= 161; k++) begin
            tick();
            checkOutput("t6_dout_tail", Dout, (k <= 120) ? 32'd22 : 32'd31);
        end
        checkOutput("t6_ready_end", cmd_ready, 1);
        checkOutput("t6_busy_end", busy, 0);
        checkOutput("t6_sent_end", sent_cnt, 5);

        // Counter wrap after 256 commands.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 255; i++) applyStimulus(5'(i % 26));
        waitIdle(1000);
        checkOutput("t7_sent255", sent_cnt, 255);
        applyStimulus(5'd3);
        waitIdle(1000);
        checkOutput("t7_sent_wrap", sent_cnt, 0);

`ifdef CUT_CMD_TX_FIFO_EN
        // Back-to-back burst into the FIFO, each code held and separated by exact gaps.
        cmd_valid = 1'b1;
        cmd_code  = 5'd21; #1; checkOutput("t8_ready0", cmd_ready, 1); tick();
        cmd_code  = 5'd3;  checkOutput("t8_ready1", cmd_ready, 1); tick();
        cmd_code  = 5'd25; checkOutput("t8_ready2", cmd_ready, 1); tick();
        cmd_code  = 5'd24; checkOutput("t8_ready3", cmd_ready, 1); tick();
        cmd_valid = 1'b0;
        for (int k = 4; k <= 321; k++) begin
            logic [31:0] expd;
            expd = 32'd31;
            if (k >= 2 && k < 42) expd = 32'd21;
            if (k >= 82 && k < 122) expd = 32'd3;
            if (k >= 162 && k < 202) expd = 32'd25;
            if (k >= 242 && k < 282) expd = 32'd24;
            checkOutput("t8_dout", Dout, expd);
            tick();
        end
        checkOutput("t8_sent", sent_cnt, 4);
        checkOutput("t8_busy", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
